// File: rtl/gf163_inverter_if.sv
// Handshake and operand/result bundle between the field-arithmetic controller and the GF(2^163) inverter.
interface gf163_inverter_if #(
   parameter int M     = 163,
   parameter int CNT_W = 11
);
   logic             start;
   logic [M-1:0]     a_in;
   logic             ready;
   logic             done;
   logic [M-1:0]     inv_out;
   logic             zero_err;
   logic [CNT_W-1:0] cycles;

   modport master (
      output start,
      output a_in,
      input  ready,
      input  done,
      input  inv_out,
      input  zero_err,
      input  cycles
   );

   modport slave (
      input  start,
      input  a_in,
      output ready,
      output done,
      output inv_out,
      output zero_err,
      output cycles
   );
endinterface

// File: rtl/gf163_inverter.sv
// Sequential GF(2^163) inverter using the binary extended Euclidean algorithm,
// one reduction step per clock; invariants A = U*a and B = V*a (mod f) hold throughout.
module gf163_inverter #(
   parameter int             M     = 163,
   parameter logic [M-1:0]   F_LOW = {{(M-8){1'b0}}, 8'hC9},
   parameter int             CNT_W = 11
) (
   input logic              clk,
   input logic              rst,
   gf163_inverter_if.slave  io_bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [M:0]       F_FULL  = {1'b1, F_LOW};
   localparam logic [M:0]       ONE     = {{M{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(4 * M);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_stateNext;

   logic [M:0]       r_a;
   logic [M:0]       r_b;
   logic [M:0]       r_u;
   logic [M:0]       r_v;
   logic [M:0]       w_aNext;
   logic [M:0]       w_bNext;
   logic [M:0]       w_uNext;
   logic [M:0]       w_vNext;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_cycles;
   logic [M-1:0]     r_inv;
   logic             r_zeroErr;
   logic             r_done;

   logic             w_accept;
   logic             w_zeroOp;
   logic             w_aIsOne;
   logic             w_bIsOne;
   logic             w_finish;

   // Division by x modulo f: add f first when odd so the shifted-out bit is zero.
   function automatic logic [M:0] halveMod(input logic [M:0] x);
      logic [M:0] t;
      t = x[0] ? (x ^ F_FULL) : x;
      return t >> 1;
   endfunction

   always_comb begin
      w_accept = (r_state != S_RUN) && io_bus.start;
      w_zeroOp = (io_bus.a_in == '0);
      w_aIsOne = (r_a == ONE);
      w_bIsOne = (r_b == ONE);
      w_finish = (r_state == S_RUN) && (w_aIsOne || w_bIsOne);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (io_bus.start) begin
               w_stateNext = w_zeroOp ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_aIsOne || w_bIsOne) begin
               w_stateNext = S_DONE;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // Exactly one reduction action per RUN cycle, chosen by priority.
   always_comb begin
      w_aNext = r_a;
      w_bNext = r_b;
      w_uNext = r_u;
      w_vNext = r_v;
      if (w_accept && !w_zeroOp) begin
         w_aNext = {1'b0, io_bus.a_in};
         w_bNext = F_FULL;
         w_uNext = ONE;
         w_vNext = '0;
      end else if ((r_state == S_RUN) && !w_aIsOne && !w_bIsOne) begin
         if (!r_a[0]) begin
            w_aNext = r_a >> 1;
            w_uNext = halveMod(r_u);
         end else if (!r_b[0]) begin
            w_bNext = r_b >> 1;
            w_vNext = halveMod(r_v);
         end else if (r_a >= r_b) begin
            w_aNext = r_a ^ r_b;
            w_uNext = r_u ^ r_v;
         end else begin
            w_bNext = r_b ^ r_a;
            w_vNext = r_v ^ r_u;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_u       <= '0;
         r_v       <= '0;
         r_cnt     <= '0;
         r_cycles  <= '0;
         r_inv     <= '0;
         r_zeroErr <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_a    <= w_aNext;
         r_b    <= w_bNext;
         r_u    <= w_uNext;
         r_v    <= w_vNext;
         r_done <= w_finish || (w_accept && w_zeroOp);
         if (w_accept) begin
            r_cnt <= '0;
            if (w_zeroOp) begin
               r_inv     <= '0;
               r_zeroErr <= 1'b1;
               r_cycles  <= '0;
            end else begin
               r_zeroErr <= 1'b0;
            end
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_finish) begin
               r_cycles <= r_cnt + CNT_ONE;
               r_inv    <= w_aIsOne ? r_u[M-1:0] : r_v[M-1:0];
            end
         end
      end
   end

   always_comb begin
      io_bus.ready    = (r_state == S_IDLE) || (r_state == S_DONE);
      io_bus.done     = r_done;
      io_bus.inv_out  = r_inv;
      io_bus.zero_err = r_zeroErr;
      io_bus.cycles   = r_cycles;
   end

   // The Euclidean loop must converge within 4*M steps and keep U, V reduced.
   runBound: assert property (@(posedge clk) disable iff (rst)
      (r_state == S_RUN) |-> (r_cnt < MAX_RUN));

   uvReduced: assert property (@(posedge clk) disable iff (rst)
      (!r_u[M] && !r_v[M]));

endmodule

// File: tb/tb_gf163_inverter.sv
// Randomized scoreboard bench for gf163_inverter: stimulus queues expectations,
// a negedge monitor checks each done against a GF(2^163) multiply model.
module tb_gf163_inverter;

   localparam int M        = 163;
   localparam int CNT_W    = 11;
   localparam int CLK_HALF = 5;
   localparam logic [M:0]   F_FULL = {1'b1, {(M-8){1'b0}}, 8'hC9};
   localparam logic [M-1:0] X_INV  = {1'b1, {(M-8){1'b0}}, 7'h64};
   localparam logic [M-1:0] ONE_M  = {{(M-1){1'b0}}, 1'b1};

   typedef struct {
      logic [M-1:0] a;
      int           issueCnt;
      int           expLat;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   int   edgeCount   = 0;
   int   nCompared   = 0;
   int   nMismatched = 0;
   txn_t sbq[$];

   always #CLK_HALF clk = ~clk;
   always @(posedge clk) edgeCount <= edgeCount + 1;

   gf163_inverter_if #(.M(M), .CNT_W(CNT_W)) bus ();

   gf163_inverter #(.M(M), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   // Schoolbook product followed by reduction modulo f.
   function automatic logic [M-1:0] gfMul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [2*M-1:0] p;
      p = '0;
      for (int i = 0; i < M; i++) begin
         if (y[i]) p ^= ({{M{1'b0}}, x} << i);
      end
      for (int i = 2*M-2; i >= M; i--) begin
         if (p[i]) p ^= ({{(M-1){1'b0}}, F_FULL} << (i - M));
      end
      return p[M-1:0];
   endfunction

   function automatic logic [M-1:0] randWide();
      logic [M-1:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) r = {r[M-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic waitReady();
      int guard = 0;
      while (bus.ready !== 1'b1 && guard < 4*M + 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("ready_wait", M'(bus.ready), ONE_M);
   endtask

   task automatic applyStimulus(input logic [M-1:0] a, input bit track);
      int expLat;
      waitReady();
      expLat = (a == '0) ? 1 : ((a == ONE_M) ? 2 : 0);
      bus.start = 1'b1;
      bus.a_in  = a;
      if (track) sbq.push_back('{a, edgeCount, expLat});
      @(negedge clk);
      bus.start = 1'b0;
      bus.a_in  = randWide();
   endtask

   always @(negedge clk) begin : monitor
      txn_t t;
      int   lat;
      if (bus.done === 1'b1) begin
         if (sbq.size() == 0) begin
            checkOutput("done_without_start", M'(bus.done), '0);
         end else begin
            t   = sbq.pop_front();
            lat = edgeCount - t.issueCnt;
            if (t.expLat > 0) checkOutput("latency", M'(lat), M'(t.expLat));
            else checkOutput("latency_bound", M'(lat >= 2 && lat <= 4*M + 1), ONE_M);
            if (t.a == '0) begin
               checkOutput("zero_err_set", M'(bus.zero_err), ONE_M);
               checkOutput("zero_inv", bus.inv_out, '0);
               checkOutput("zero_cycles", M'(bus.cycles), '0);
            end else begin
               checkOutput("zero_err_clear", M'(bus.zero_err), '0);
               checkOutput("inverse_product", gfMul(t.a, bus.inv_out), ONE_M);
               checkOutput("cycles_bound", M'(bus.cycles >= 1 && bus.cycles <= 4*M), ONE_M);
               if (t.a == ONE_M) checkOutput("cycles_a1", M'(bus.cycles), ONE_M);
               if (t.a == M'(2)) checkOutput("inv_x", bus.inv_out, X_INV);
            end
         end
      end
   end

   initial begin : watchdog
      #(2 * CLK_HALF * 150000);
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [M-1:0] a;
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a_in  = randWide();
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", M'(bus.ready), ONE_M);
      checkOutput("reset_done", M'(bus.done), '0);
      checkOutput("reset_inv", bus.inv_out, '0);
      checkOutput("reset_zero_err", M'(bus.zero_err), '0);
      checkOutput("reset_cycles", M'(bus.cycles), '0);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);

      applyStimulus(ONE_M, 1'b1);
      applyStimulus(M'(2), 1'b1);
      applyStimulus('0, 1'b1);
      applyStimulus(M'(3), 1'b1);

      for (int n = 0; n < 100; n++) begin
         a = randWide();
         if ($urandom_range(0, 3) == 0) a = (a >> $urandom_range(1, 160)) | ONE_M;
         if (a == '0) a = ONE_M;
         applyStimulus(a, 1'b1);
         if (n % 4 == 0) begin
            for (int k = 0; k < 3; k++) begin
               if (bus.ready === 1'b0) begin
                  bus.start = 1'b1;
                  bus.a_in  = randWide();
               end
               @(negedge clk);
               bus.start = 1'b0;
            end
         end
         if ($urandom_range(0, 2) == 0) begin
            waitReady();
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end

      applyStimulus({M{1'b1}}, 1'b0);
      repeat (49) @(negedge clk);
      checkOutput("busy_before_abort", M'(bus.ready), '0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_ready", M'(bus.ready), ONE_M);
      checkOutput("abort_done", M'(bus.done), '0);
      checkOutput("abort_inv", bus.inv_out, '0);
      checkOutput("abort_cycles", M'(bus.cycles), '0);
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", M'(bus.done), '0);

      applyStimulus(M'(2), 1'b1);
      waitReady();
      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", M'(sbq.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
